masked_and_scheduler: RTL and testbench

MASKED_AND_SCHEDULER -- requirements
Module: masked_and_scheduler

---
 rtl/masked_and_scheduler.sv | 168 ++++++++++++++++
 tb/tb_masked_and_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_and_scheduler.sv
// Round-robin scheduler that feeds one shared masked AND unit with operand shares and fresh randomness.
// Optional macro MASKED_SHARE_CLEAR_EN adds a CLEAR cycle that wipes the operand registers after each result.
module masked_and_scheduler #(
    parameter int D   = 3,
    parameter int N   = 4,
    parameter int LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*D-1:0]         opa,
    input  logic [N*D-1:0]         opb,
    output logic [D-1:0]           res,
    output logic [N-1:0]           res_valid,
    input  logic [D*(D-1)/2-1:0]   rnd_in,
    input  logic                   rnd_valid,
    output logic                   rnd_ack,
    output logic [D-1:0]           and_ina,
    output logic [D-1:0]           and_inb,
    output logic [D*(D-1)/2-1:0]   and_rin,
    output logic                   and_enable,
    input  logic                   and_done,
    input  logic [D-1:0]           and_out,
    output logic                   busy,
    output logic                   sync_err
);

    localparam int R  = D * (D - 1) / 2;
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_CLEAR
    } state_t;

    state_t          state_reg;
    logic [GW-1:0]   grant_reg;
    logic [GW-1:0]   last_grant_reg;
    logic [CW-1:0]   run_cnt_reg;
    logic [D-1:0]    res_reg;
    logic [N-1:0]    res_valid_reg;
    logic            rnd_ack_reg;
    logic            and_enable_reg;
    logic [D-1:0]    and_ina_reg;
    logic [D-1:0]    and_inb_reg;
    logic [R-1:0]    and_rin_reg;
    logic            sync_err_reg;

    logic [GW-1:0]   grant_next;
    logic            grant_found;

    logic [D-1:0]    opa_sl [N];
    logic [D-1:0]    opb_sl [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign opa_sl[gi] = opa[gi*D +: D];
            assign opb_sl[gi] = opb[gi*D +: D];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the requester right after last_grant wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_next  = last_grant_reg;
        grant_found = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_grant_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                grant_next  = GW'(idx);
                grant_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(N - 1);
            run_cnt_reg    <= '0;
            res_reg        <= '0;
            res_valid_reg  <= '0;
            rnd_ack_reg    <= 1'b0;
            and_enable_reg <= 1'b0;
            and_ina_reg    <= '0;
            and_inb_reg    <= '0;
            and_rin_reg    <= '0;
            sync_err_reg   <= 1'b0;
        end else begin
            rnd_ack_reg   <= 1'b0;
            res_valid_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (grant_found) begin
                        grant_reg      <= grant_next;
                        last_grant_reg <= grant_next;
                        state_reg      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (rnd_valid) begin
                        and_ina_reg    <= opa_sl[grant_reg];
                        and_inb_reg    <= opb_sl[grant_reg];
                        and_rin_reg    <= rnd_in;
                        rnd_ack_reg    <= 1'b1;
                        and_enable_reg <= 1'b1;
                        run_cnt_reg    <= '0;
                        state_reg      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_cnt_reg == CW'(LAT - 1)) begin
                        // A late done is flagged but the captured value is still handed back.
                        if (!and_done) begin
                            sync_err_reg <= 1'b1;
                        end
                        res_reg                  <= and_out;
                        res_valid_reg[grant_reg] <= 1'b1;
                        and_enable_reg           <= 1'b0;
                        run_cnt_reg              <= '0;
                        state_reg                <= S_DONE;
                    end else begin
                        if (and_done) begin
                            sync_err_reg <= 1'b1;
                        end
                        run_cnt_reg <= run_cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
`ifdef MASKED_SHARE_CLEAR_EN
                    and_ina_reg <= '0;
                    and_inb_reg <= '0;
                    and_rin_reg <= '0;
                    state_reg   <= S_CLEAR;
`else
                    state_reg   <= S_IDLE;
`endif
                end
                S_CLEAR: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign res        = res_reg;
    assign res_valid  = res_valid_reg;
    assign rnd_ack    = rnd_ack_reg;
    assign and_enable = and_enable_reg;
    assign and_ina    = and_ina_reg;
    assign and_inb    = and_inb_reg;
    assign and_rin    = and_rin_reg;
    assign busy       = (state_reg != S_IDLE);
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_masked_and_scheduler.sv
// Self-checking bench for masked_and_scheduler: behavioural AND unit plus a result scoreboard.
module tb_masked_and_scheduler;

    localparam int D   = 3;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int R   = D * (D - 1) / 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*D-1:0] opa;
    logic [N*D-1:0] opb;
    logic [D-1:0]   res;
    logic [N-1:0]   res_valid;
    logic [R-1:0]   rnd_in;
    logic           rnd_valid;
    logic           rnd_ack;
    logic [D-1:0]   and_ina;
    logic [D-1:0]   and_inb;
    logic [R-1:0]   and_rin;
    logic           and_enable;
    logic           and_done;
    logic [D-1:0]   and_out;
    logic           busy;
    logic           sync_err;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [N-1:0] v;
        logic [D-1:0] r;
    } exp_t;
    exp_t sb[$];

    logic force_done_low = 1'b0;
    int   model_cnt = 0;

    masked_and_scheduler #(.D(D), .N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
        .res(res), .res_valid(res_valid), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
        .rnd_ack(rnd_ack), .and_ina(and_ina), .and_inb(and_inb), .and_rin(and_rin),
        .and_enable(and_enable), .and_done(and_done), .and_out(and_out),
        .busy(busy), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Stand-in transfer function for the AND unit, chosen to depend on all three inputs.
    function automatic logic [D-1:0] model_and(input logic [D-1:0] a, input logic [D-1:0] b,
                                               input logic [R-1:0] r);
        return (~a & b) ^ (r & ~a & ~b);
    endfunction

    always @(posedge clk) model_cnt <= and_enable ? model_cnt + 1 : 0;
    assign and_done = and_enable && (model_cnt == LAT - 1) && !force_done_low;
    assign and_out  = model_and(and_ina, and_inb, and_rin);

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (res_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: res_valid=%b res=%b, required no result", res_valid, res);
            end else begin
                e = sb.pop_front();
                if (res_valid !== e.v || res !== e.r) begin
                    fails++;
                    $display("FAIL result: res_valid=%b res=%b, required res_valid=%b res=%b",
                             res_valid, res, e.v, e.r);
                end else begin
                    $display("result res_valid=%b res=%b", res_valid, res);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        rnd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_res(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (res_valid !== '0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; rnd_valid = 1'b1; rnd_in = '1; opa = '1; opb = '1;
        tick();
        tick();
        checks++;
        if ({res, res_valid, rnd_ack, and_enable} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: res=%b res_valid=%b rnd_ack=%b and_enable=%b, required all 0",
                     res, res_valid, rnd_ack, and_enable);
        end
        checks++;
        if ({and_ina, and_inb, and_rin} !== '0) begin
            fails++;
            $display("FAIL reset_operands: ina=%b inb=%b rin=%b, required 0", and_ina, and_inb, and_rin);
        end
        checks++;
        if (busy !== 1'b0 || sync_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: busy=%b sync_err=%b, required 0 0", busy, sync_err);
        end
        rst = 1'b0; req = '0; rnd_valid = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_single();
        int acks = 0;
        int ens = 0;
        int lat = -1;
        do_reset();
        opa = '0; opb = '0;
        opa[2:0] = 3'b101; opb[2:0] = 3'b011; rnd_in = 3'b110; rnd_valid = 1'b1;
        sb.push_back('{4'b0001, 3'b010});
        req = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rnd_ack === 1'b1) begin
                acks++;
                checks++;
                if (and_ina !== 3'b101 || and_inb !== 3'b011 || and_rin !== 3'b110) begin
                    fails++;
                    $display("FAIL single_operands: ina=%b inb=%b rin=%b, required 101 011 110",
                             and_ina, and_inb, and_rin);
                end
            end
            if (and_enable === 1'b1) ens++;
            if (res_valid !== '0) begin
                lat = i;
                break;
            end
        end
        req = '0;
        checks++;
        if (acks !== 1 || ens !== LAT) begin
            fails++;
            $display("FAIL single_counts: rnd_ack=%0d enable_cycles=%0d, required 1 %0d", acks, ens, LAT);
        end
        checks++;
        if (lat !== LAT + 2) begin
            fails++;
            $display("FAIL single_latency: %0d cycles, required %0d", lat, LAT + 2);
        end
        checks++;
        if (sync_err !== 1'b0) begin
            fails++;
            $display("FAIL single_sync_err: %b, required 0", sync_err);
        end
        tick();
        checks++;
`ifdef MASKED_SHARE_CLEAR_EN
        if ({and_ina, and_inb, and_rin} !== '0 || and_enable !== 1'b0) begin
            fails++;
            $display("FAIL share_clear: ina=%b inb=%b rin=%b en=%b, required 0 0 0 0",
                     and_ina, and_inb, and_rin, and_enable);
        end
`else
        if (and_ina !== 3'b101 || and_inb !== 3'b011 || and_rin !== 3'b110 || and_enable !== 1'b0) begin
            fails++;
            $display("FAIL share_retain: ina=%b inb=%b rin=%b en=%b, required 101 011 110 0",
                     and_ina, and_inb, and_rin, and_enable);
        end
`endif
        $display("single request done, latency %0d", lat);
    endtask

    task automatic test_contention();
        logic [R-1:0] rnd_seq [5];
        int acks = 0;
        int nres = 0;
        int i;
        rnd_seq[0] = 3'b110; rnd_seq[1] = 3'b011; rnd_seq[2] = 3'b101;
        rnd_seq[3] = 3'b001; rnd_seq[4] = 3'b111;
        do_reset();
        opa = {3'b011, 3'b111, 3'b010, 3'b101};
        opb = {3'b100, 3'b001, 3'b110, 3'b011};
        for (int k = 0; k < 5; k++) begin
            i = k % N;
            sb.push_back('{4'(1 << i), model_and(opa[i*D +: D], opb[i*D +: D], rnd_seq[k])});
        end
        rnd_in = rnd_seq[0];
        rnd_valid = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (rnd_ack === 1'b1) begin
                checks++;
                if (acks < 5 && (and_rin !== rnd_seq[acks] || and_ina !== opa[(acks % N)*D +: D])) begin
                    fails++;
                    $display("FAIL contention_operands: op %0d ina=%b rin=%b, required %b %b",
                             acks, and_ina, and_rin, opa[(acks % N)*D +: D], rnd_seq[acks]);
                end
                acks++;
                if (acks < 5) rnd_in = rnd_seq[acks];
            end
            if (res_valid !== '0) begin
                nres++;
                if (nres == 5) begin
                    req = '0;
                    break;
                end
            end
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rnd_ack === 1'b1) acks++;
        end
        checks++;
        if (nres !== 5 || acks !== 5) begin
            fails++;
            $display("FAIL contention_counts: results=%0d rnd_ack=%0d, required 5 5", nres, acks);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL contention_idle: busy=%b, required 0", busy);
        end
        $display("contention done, %0d operations", nres);
    endtask

    task automatic test_rnd_stall();
        int lat;
        do_reset();
        opa = '0; opb = '0;
        opa[5:3] = 3'b001; opb[5:3] = 3'b110; rnd_in = 3'b010; rnd_valid = 1'b0;
        sb.push_back('{4'b0010, model_and(3'b001, 3'b110, 3'b010)});
        req = 4'b0010;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (busy !== 1'b1 || and_enable !== 1'b0 || rnd_ack !== 1'b0) begin
                fails++;
                $display("FAIL stall_load: cycle %0d busy=%b en=%b ack=%b, required 1 0 0",
                         c, busy, and_enable, rnd_ack);
            end
            tick();
        end
        rnd_valid = 1'b1;
        tick();
        checks++;
        if (and_enable !== 1'b1 || rnd_ack !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: en=%b ack=%b, required 1 1", and_enable, rnd_ack);
        end
        wait_res(20, lat);
        req = '0;
        checks++;
        if (lat < 0) begin
            fails++;
            $display("FAIL stall_result: no res_valid within budget, required one");
        end
        $display("randomness stall done");
    endtask

    task automatic test_reset_in_run();
        int lat;
        do_reset();
        opa = '0; opb = '0;
        opa[8:6] = 3'b100; opb[8:6] = 3'b010; rnd_in = 3'b101; rnd_valid = 1'b1;
        req = 4'b0100;
        tick();
        tick();
        tick();
        checks++;
        if (and_enable !== 1'b1) begin
            fails++;
            $display("FAIL run_enable: en=%b, required 1", and_enable);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (and_enable !== 1'b0 || busy !== 1'b0 || res_valid !== '0) begin
            fails++;
            $display("FAIL run_abort: en=%b busy=%b res_valid=%b, required 0 0 0",
                     and_enable, busy, res_valid);
        end
        sb.push_back('{4'b0100, model_and(3'b100, 3'b010, 3'b101)});
        wait_res(20, lat);
        req = '0;
        checks++;
        if (lat < 0) begin
            fails++;
            $display("FAIL run_recover: no res_valid within budget, required one");
        end
        $display("reset in RUN done");
    endtask

    task automatic test_sync_err();
        int lat;
        do_reset();
        opa = '0; opb = '0;
        opa[11:9] = 3'b000; opb[11:9] = 3'b101; rnd_in = 3'b011; rnd_valid = 1'b1;
        force_done_low = 1'b1;
        sb.push_back('{4'b1000, model_and(3'b000, 3'b101, 3'b011)});
        req = 4'b1000;
        wait_res(20, lat);
        req = '0;
        checks++;
        if (lat < 0 || sync_err !== 1'b1) begin
            fails++;
            $display("FAIL sync_err_set: lat=%0d sync_err=%b, required result and 1", lat, sync_err);
        end
        force_done_low = 1'b0;
        tick();
        tick();
        opa[2:0] = 3'b010; opb[2:0] = 3'b010; rnd_in = 3'b100;
        sb.push_back('{4'b0001, model_and(3'b010, 3'b010, 3'b100)});
        req = 4'b0001;
        wait_res(20, lat);
        req = '0;
        checks++;
        if (lat < 0 || sync_err !== 1'b1) begin
            fails++;
            $display("FAIL sync_err_sticky: lat=%0d sync_err=%b, required result and 1", lat, sync_err);
        end
        do_reset();
        checks++;
        if (sync_err !== 1'b0) begin
            fails++;
            $display("FAIL sync_err_clear: %b, required 0", sync_err);
        end
        $display("sync_err done");
    endtask

    initial begin
        rst = 1'b1; req = '0; opa = '0; opb = '0; rnd_in = '0; rnd_valid = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_rnd_stall();
        test_reset_in_run();
        test_sync_err();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
